// File: rtl/sum_moving_avg_if.sv
// rtl/sum_moving_avg_if.sv - sample-in / average-out bundle for the moving-average stage
interface sum_moving_avg_if #(
    parameter int DATA_W = 9
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              clear;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              win_full;
    logic [DATA_W-1:0] peak_out;

    modport master (
        output in_valid, in_data, clear,
        input  avg_out, avg_valid, win_full, peak_out
    );

    modport slave (
        input  in_valid, in_data, clear,
        output avg_out, avg_valid, win_full, peak_out
    );
endinterface

// File: rtl/sum_moving_avg.sv
// rtl/sum_moving_avg.sv - sliding-window moving average over the last 2^LOG2_DEPTH sum samples
// Optional running peak register enabled by SUM_AVG_PEAK_EN.
module sum_moving_avg #(
    parameter int DATA_W     = 9,
    parameter int LOG2_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    sum_moving_avg_if.slave  bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int ACC_W = DATA_W + LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic {FILL, RUN} state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [DATA_W-1:0]       avg_q, avg_d;
    logic                    avg_valid_q, avg_valid_d;
    logic                    win_full_q, win_full_d;
    logic                    wr_en;
    logic [DATA_W-1:0]       oldest;

    // Oldest entry is read combinationally, so the same edge that overwrites it sees the old value.
    assign oldest = mem_q[wr_ptr_q];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        wr_en       = 1'b0;

        if (bus.clear) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            count_d  = '0;
            acc_d    = '0;
        end else if (bus.in_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
            case (state_q)
                FILL: begin
                    acc_d   = acc_q + ACC_W'(bus.in_data);
                    count_d = count_q + CNT_W'(1);
                    if (count_d == CNT_FULL) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d = acc_q + ACC_W'(bus.in_data) - ACC_W'(oldest);
                end
                default: state_d = FILL;
            endcase
            if (count_d == CNT_FULL) begin
                avg_d       = acc_d[ACC_W-1:LOG2_DEPTH];
                avg_valid_d = 1'b1;
            end
        end

        win_full_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            win_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            win_full_q  <= win_full_d;
        end
    end

    // Sample storage needs no reset: entries are only read once the window has been refilled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef SUM_AVG_PEAK_EN
    logic [DATA_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (bus.clear) begin
            peak_d = '0;
        end else if (bus.in_valid && (bus.in_data > peak_q)) begin
            peak_d = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign bus.peak_out = peak_q;
`else
    assign bus.peak_out = '0;
`endif

    assign bus.avg_out   = avg_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.win_full  = win_full_q;
endmodule

// File: tb/tb_sum_moving_avg.sv
// tb/tb_sum_moving_avg.sv - scoreboard bench for sum_moving_avg with directed window patterns
module tb_sum_moving_avg;
    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    int   peak_on;
    int   exp_q [$];

    sum_moving_avg_if #(.DATA_W(9)) bus ();

    sum_moving_avg #(.DATA_W(9), .LOG2_DEPTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every avg_valid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.avg_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_pulse: got avg %0d expected no pulse", bus.avg_out);
            end else begin
                check("avg_out", int'(bus.avg_out), exp_q.pop_front());
                check("win_full_on_pulse", int'(bus.win_full), 1);
            end
        end
    end

    task automatic send(input int d, input bit push, input int exp);
        if (push) exp_q.push_back(exp);
        bus.in_valid = 1'b1;
        bus.in_data  = 9'(d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_half(input int d, input bit push, input int exp);
        send(d, push, exp);
        idle(1);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
`ifdef SUM_AVG_PEAK_EN
        peak_on  = 1;
`else
        peak_on  = 0;
`endif
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clear    = 1'b0;
        rst_n        = 1'b0;
        idle(2);
        check("rst_avg_out", int'(bus.avg_out), 0);
        check("rst_avg_valid", int'(bus.avg_valid), 0);
        check("rst_win_full", int'(bus.win_full), 0);
        check("rst_peak_out", int'(bus.peak_out), 0);
        rst_n = 1'b1;
        idle(1);

        // Fill with 100 on half-rate strobes; only the 8th sample pulses.
        for (int i = 0; i < 7; i++) send_half(100, 0, 0);
        check("fill7_win_full", int'(bus.win_full), 0);
        check("fill7_avg_out", int'(bus.avg_out), 0);
        send_half(100, 1, 100);
        check("fill8_win_full", int'(bus.win_full), 1);

        // 7*100 + 500 = 1200 -> 150
        send_half(500, 1, 150);

        do_clear();
        check("clear_win_full", int'(bus.win_full), 0);
        check("clear_keeps_avg", int'(bus.avg_out), 150);

        // Back-to-back maximum samples: 8*511 = 4088 -> 511
        for (int i = 0; i < 7; i++) send(511, 0, 0);
        send(511, 1, 511);
        idle(1);
        check("max_win_full", int'(bus.win_full), 1);

        // Truncation: 3+7*4 = 31 -> 3
        do_clear();
        send_half(3, 0, 0);
        for (int i = 0; i < 6; i++) send_half(4, 0, 0);
        send_half(4, 1, 3);
        check("peak_after_trunc", int'(bus.peak_out), peak_on ? 4 : 0);
        // Pointer has wrapped: 12 replaces the oldest 3 -> 7*4+12 = 40 -> 5
        send_half(12, 1, 5);
        check("peak_after_wrap", int'(bus.peak_out), peak_on ? 12 : 0);

        // Clear wins over a simultaneous sample; the refill starts from zero.
        do_clear();
        for (int i = 0; i < 5; i++) send_half(50, 0, 0);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 9'd200;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_valid_win_full", int'(bus.win_full), 0);
        check("clear_valid_peak", int'(bus.peak_out), 0);
        for (int i = 0; i < 7; i++) send_half(10, 0, 0);
        check("refill7_win_full", int'(bus.win_full), 0);
        send_half(10, 1, 10);
        check("refill_peak", int'(bus.peak_out), peak_on ? 10 : 0);

        // Asynchronous reset mid-cycle while a pulse is high.
        send(10, 0, 0);
        check("pre_reset_avg_valid", int'(bus.avg_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_avg_out", int'(bus.avg_out), 0);
        check("async_rst_avg_valid", int'(bus.avg_valid), 0);
        check("async_rst_win_full", int'(bus.win_full), 0);
        check("async_rst_peak", int'(bus.peak_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) send_half(7, 0, 0);
        check("rst_refill7_win_full", int'(bus.win_full), 0);
        send_half(7, 1, 7);

        idle(4);
        check("pending_pulses", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/sum_moving_avg.md
# sum_moving_avg

Sliding-window moving-average stage fed by the registered 9-bit operand-sum stage. Accepts one sum sample per `in_valid` strobe (nominally every second `clk`, matching the half-rate update of the sum stage), keeps the last 2^LOG2_DEPTH samples in a circular buffer and maintains a running sum. Emits the truncated window average with a one-cycle valid pulse once the window is full. Output drives `uo_out` in the top-level wrapper.

## Interface
- `DATA_W`, default 9: sample width; covers the full carry-out of the 8+8 bit sum.
- `LOG2_DEPTH`, default 3: log2 of the window depth; depth 8 by default, legal range 1..4.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: sample strobe; `in_data` is accepted on any rising edge where it is high.
- `in_data` input DATA_W: unsigned sample.
- `clear` input 1: synchronous flush of the window.
- `avg_out` output DATA_W: last computed window average.
- `avg_valid` output 1: one-cycle pulse when `avg_out` updates with a full window.
- `win_full` output 1: high while the window holds DEPTH samples.
- `peak_out` output DATA_W: maximum sample since reset or clear; only with `SUM_AVG_PEAK_EN`.

## Operation
- Storage:
  - DEPTH x DATA_W buffer.
  - `wr_ptr` of LOG2_DEPTH bits.
  - `count` of LOG2_DEPTH+1 bits, saturating at DEPTH.
  - `acc` of DATA_W+LOG2_DEPTH bits; it cannot overflow.
- FSM with two states:
  - FILL: reset state, `count` < DEPTH.
  - RUN: `count` == DEPTH.
  - FILL→RUN on the accepted sample that makes `count` reach DEPTH.
  - RUN→FILL only on `clear` or reset.
- Accepted sample in FILL:
  - `buf[wr_ptr] <= in_data`, `acc <= acc + in_data`, `count++`, `wr_ptr++`.
- Accepted sample in RUN:
  - oldest = `buf[wr_ptr]`, read before the write.
  - `acc <= acc + in_data - oldest`, `buf[wr_ptr] <= in_data`, `wr_ptr++`.
- Pointer arithmetic: `wr_ptr` wraps from DEPTH-1 to 0 with natural modulo arithmetic.
- Average computation:
  - On any accepted sample whose post-update `count` == DEPTH: `avg_out <= new_acc >> LOG2_DEPTH`, which truncates (floor), and `avg_valid <= 1`.
  - Otherwise `avg_valid <= 0`.
  - `avg_out` holds its value between updates.
- `win_full` = (state == RUN), registered.
- `clear`:
  - Zeroes `acc`, `count`, `wr_ptr` and `avg_valid`, and forces FILL.
  - `avg_out` and buffer contents are left unchanged; stale buffer entries are never read in FILL.
- `clear` together with `in_valid`: `clear` wins and the sample is dropped.
- Reset values:
  - `avg_out`, `peak_out`, `avg_valid`, `win_full` = 0.
  - `acc`, `count`, `wr_ptr` = 0; state FILL.
  - Buffer contents are don't-care.
- Reset mid-window: all in-flight state is discarded; the next sample restarts the fill from zero.

## Timing
- Latency: sample accepted at edge k, `avg_out`/`avg_valid` visible after edge k.
- `avg_valid` is high for exactly one cycle per accepted sample in RUN, including the filling sample.
- No backpressure: the block accepts `in_valid` on every cycle, back-to-back, with no stalls.
- Half-rate strobes produce `avg_valid` pulses spaced by at least 2 cycles.
- `in_data` is ignored when `in_valid` is low; the FSM does not advance.
- The read of the oldest entry and the write to the same index resolve in one edge, with read-before-write semantics.

## Configuration
- `SUM_AVG_PEAK_EN` defined:
  - `peak_out <= max(peak_out, in_data)` on each accepted sample, updated on the same edge as `acc`.
  - Cleared to 0 by `clear` and by reset.
- `SUM_AVG_PEAK_EN` undefined:
  - No peak register is built and `peak_out` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then 8 samples of 100 on half-rate strobes → `avg_valid` first pulses after the 8th sample with `avg_out`=100, `win_full`=1; no pulse after samples 1–7.
- Full window of 100, then one sample of 500 → `acc`=1200, `avg_out`=150, one `avg_valid` pulse.
- 8 samples of 511 back-to-back every cycle → `avg_out`=511 and `acc`=4088 with no overflow; `avg_valid` high on the 8th edge; `wr_ptr` wraps to 0.
- Samples 3,4,4,4,4,4,4,4 → `avg_out`=3 (31>>3, truncation); with `SUM_AVG_PEAK_EN`, `peak_out`=4.
- After 5 samples, assert `clear` together with `in_valid` (data 200) → `count`=0 and the sample is dropped; 8 further samples of 10 give `avg_out`=10.
- Assert `rst_n` low asynchronously mid-clock during RUN → all outputs 0 immediately; a refill of 8 samples of 7 gives `avg_out`=7.
